// File: rtl/encoder8to3_seq_pkg.sv
// Shared constants and types for the registered 8-to-3 priority encoder.
// Code k corresponds to request line D[k], the inverse of the 3-to-8 decoder.
package enc_pkg;

  localparam int W  = 8;
  localparam int AW = $clog2(W);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  typedef logic [AW-1:0] code_t;

endpackage

// File: rtl/encoder8to3_seq_if.sv
// Request/serve bundle between request sources, the encoder and its consumer.
// The source side (master) drives E/D/ack; the encoder (slave) returns A/V/P.
interface encoder8to3_seq_if #(
  parameter int W  = 8,
  parameter int AW = $clog2(W)
);

  logic          E;
  logic [W-1:0]  D;
  logic          ack;
  logic [AW-1:0] A;
  logic          V;
  logic [W-1:0]  P;

  modport master (output E, D, ack, input  A, V, P);
  modport slave  (input  E, D, ack, output A, V, P);

endinterface

// File: rtl/encoder8to3_seq_prio_pick.sv
// Combinational highest-set-bit finder: o_idx is the top set index of i_req,
// o_any flags that at least one bit is set (o_idx is 0 when none are).
module prio_pick #(
  parameter int W  = 8,
  parameter int AW = $clog2(W)
) (
  input  logic [W-1:0]  i_req,
  output logic [AW-1:0] o_idx,
  output logic          o_any
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    o_idx = '0;
    o_any = |i_req;
    for (int i = 0; i < W; i++) begin
      if (i_req[i]) o_idx = AW'(i);
    end
  end

endmodule

// File: rtl/encoder8to3_seq.sv
// Registered priority encoder with request latching and a valid/ack handshake.
// Define ENC_ROUND_ROBIN_EN for rotating priority; default is fixed top-index-first.
module encoder8to3_seq
  import enc_pkg::*;
#(
  parameter int W = enc_pkg::W
) (
  input  logic              clk,
  input  logic              reset,
  encoder8to3_seq_if.slave  bus
);

  localparam int AW = $clog2(W);

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_A, w_A_nxt;
  logic [W-1:0]    r_P, w_P_nxt;
  logic [W-1:0]    w_clr;
  logic [AW-1:0]   w_win;
  logic            w_any;

`ifdef ENC_ROUND_ROBIN_EN
  logic [AW-1:0]   r_last, w_last_nxt;
  logic [W-1:0]    w_rot;
  logic [AW-1:0]   w_rot_idx;

  // Rotate so that P[last-1] lands on the top bit; the plain highest-bit
  // finder then yields the first set bit scanning downward from last-1.
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < W; j++) begin
      w_rot[j] = r_P[AW'(j) + r_last];
    end
  end

  prio_pick #(.W(W), .AW(AW)) u_pick (
    .i_req (w_rot),
    .o_idx (w_rot_idx),
    .o_any (w_any)
  );

  assign w_win = w_rot_idx + r_last;
`else
  prio_pick #(.W(W), .AW(AW)) u_pick (
    .i_req (r_P),
    .o_idx (w_win),
    .o_any (w_any)
  );
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_A_nxt     = r_A;
    w_clr       = '0;
`ifdef ENC_ROUND_ROBIN_EN
    w_last_nxt  = r_last;
`endif
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_A_nxt     = w_win;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.ack) begin
          w_clr[r_A]  = 1'b1;
`ifdef ENC_ROUND_ROBIN_EN
          w_last_nxt  = r_A;
`endif
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // A new capture on the bit being cleared keeps it pending.
    w_P_nxt = (r_P & ~w_clr) | (bus.E ? bus.D : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_A     <= '0;
      r_P     <= '0;
`ifdef ENC_ROUND_ROBIN_EN
      r_last  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_A     <= w_A_nxt;
      r_P     <= w_P_nxt;
`ifdef ENC_ROUND_ROBIN_EN
      r_last  <= w_last_nxt;
`endif
    end
  end

  assign bus.A = r_A;
  assign bus.V = (r_state == HOLD);
  assign bus.P = r_P;

endmodule

// File: tb/tb_encoder8to3_seq.sv
// Self-checking bench for encoder8to3_seq: directed literal checks plus a
// randomized run compared every cycle against a spec-level reference model.
module tb_encoder8to3_seq;

  localparam int W = 8;

  logic clk;
  logic reset;

  encoder8to3_seq_if #(.W(W)) bus();

  encoder8to3_seq #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

`ifdef ENC_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Reference model: pending set as an integer mask, current code, valid flag.
  int m_P, m_A, m_last;
  bit m_V, m_ok;

  // First set bit scanning downward from start, wrapping.
  function automatic int win(int p, int start);
    for (int s = 0; s < W; s++) begin
      int i;
      i = (start - s + W) % W;
      if (((p >> i) & 1) == 1) return i;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_P <= 0; m_A <= 0; m_V <= 1'b0; m_last <= 0; m_ok <= 1'b1;
    end else begin
      m_P <= (m_P & ~((m_V && bus.ack) ? (1 << m_A) : 0)) | (bus.E ? int'(bus.D) : 0);
      if (!m_V && m_P != 0) begin
        m_A <= win(m_P, RR ? (m_last + W - 1) % W : W - 1);
        m_V <= 1'b1;
      end else if (m_V && bus.ack) begin
        m_V    <= 1'b0;
        m_last <= m_A;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      chk("model.V", int'(bus.V), int'(m_V));
      chk("model.P", int'(bus.P), m_P);
      if (m_V) chk("model.A", int'(bus.A), m_A);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input int v, input int a, input int p);
    chk({nm, ".V"}, int'(bus.V), v);
    chk({nm, ".A"}, int'(bus.A), a);
    chk({nm, ".P"}, int'(bus.P), p);
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.E = 1'b0; bus.D = '0; bus.ack = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bus.E = 1'b1; bus.D = 8'hFF; bus.ack = 1'b0;

    // Reset held two edges with requests present.
    step(); expect_out("rst0", 0, 0, 'h00);
    step(); expect_out("rst1", 0, 0, 'h00);
    reset = 1'b0;
    step(); chk("rst_release.P", int'(bus.P), 'hFF); chk("rst_release.V", int'(bus.V), 0);

    // Basic latency.
    do_reset();
    bus.E = 1'b1; bus.D = 8'h20;
    step(); expect_out("lat.cap", 0, 0, 'h20);
    bus.D = '0;
    step(); expect_out("lat.valid", 1, 5, 'h20);
    bus.ack = 1'b1;
    step(); chk("lat.ack.V", int'(bus.V), 0); chk("lat.ack.P", int'(bus.P), 0);
    bus.ack = 1'b0;

    // Fixed priority with ack held high.
    do_reset();
    bus.E = 1'b1; bus.D = 8'b1000_0101;
    step(); chk("prio.cap.P", int'(bus.P), 'h85);
    bus.D = '0; bus.ack = 1'b1;
    step(); expect_out("prio.c7", 1, 7, 'h85);
    step(); chk("prio.gap1.V", int'(bus.V), 0); chk("prio.gap1.P", int'(bus.P), 'h05);
    step(); expect_out("prio.c2", 1, 2, 'h05);
    step(); chk("prio.gap2.V", int'(bus.V), 0);
    step(); expect_out("prio.c0", 1, 0, 'h01);
    step(); chk("prio.end.V", int'(bus.V), 0); chk("prio.end.P", int'(bus.P), 0);
    bus.ack = 1'b0;

    // Higher-priority arrival during HOLD does not disturb A.
    do_reset();
    bus.E = 1'b1; bus.D = 8'h04;
    step(); bus.D = '0;
    step(); expect_out("coll.c2", 1, 2, 'h04);
    bus.D = 8'h80;
    step(); expect_out("coll.hold", 1, 2, 'h84);
    bus.D = '0;
    step(); chk("coll.hold2.A", int'(bus.A), 2);
    bus.ack = 1'b1;
    step(); chk("coll.ack.V", int'(bus.V), 0); chk("coll.ack.P", int'(bus.P), 'h80);
    bus.ack = 1'b0;
    step(); expect_out("coll.c7", 1, 7, 'h80);
    bus.ack = 1'b1;
    step(); bus.ack = 1'b0;
    // Same-edge ack and re-request: set wins.
    bus.D = 8'h04;
    step(); bus.D = '0;
    step(); chk("same.c2.A", int'(bus.A), 2);
    bus.ack = 1'b1; bus.D = 8'h04;
    step(); chk("same.kept.P", int'(bus.P), 'h04); chk("same.kept.V", int'(bus.V), 0);
    bus.ack = 1'b0; bus.D = '0;
    step(); expect_out("same.again", 1, 2, 'h04);
    bus.ack = 1'b1;
    step(); chk("same.done.P", int'(bus.P), 0);
    bus.ack = 1'b0;

    // Enable gating and reset mid-handshake.
    do_reset();
    bus.E = 1'b1; bus.D = 8'h10;
    step(); bus.E = 1'b0; bus.D = 8'hFF;
    step(); expect_out("en.off", 1, 4, 'h10);
    step(); chk("en.off2.P", int'(bus.P), 'h10);
    reset = 1'b1;
    step(); expect_out("midrst", 0, 0, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); chk("midrst.quiet.V", int'(bus.V), 0);
    end

    // Sustained all-ones: rotating order in round-robin builds, 7 forever otherwise.
    do_reset();
    bus.E = 1'b1; bus.D = 8'hFF; bus.ack = 1'b1;
    step();
    for (int k = 0; k < 9; k++) begin
      step(); chk("sat.V", int'(bus.V), 1);
      chk("sat.A", int'(bus.A), RR ? (7 - k + 8) % 8 : 7);
      step(); chk("sat.gap.V", int'(bus.V), 0);
    end

    // All-ones drained without new requests: 7..0 in order then empty.
    do_reset();
    bus.E = 1'b1; bus.D = 8'hFF;
    step(); bus.E = 1'b0; bus.D = '0; bus.ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(); chk("drain.A", int'(bus.A), 7 - k);
      step();
    end
    chk("drain.end.P", int'(bus.P), 0);
    bus.ack = 1'b0;

    // Randomized traffic checked by the model process.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 99) == 0);
      bus.E   = ($urandom_range(0, 3) != 0);
      bus.D   = 8'($urandom & $urandom & $urandom);
      bus.ack = ($urandom_range(0, 2) != 0);
      step();
    end
    reset = 1'b0; bus.E = 1'b0; bus.D = '0; bus.ack = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
